eic_irq_sequencer: RTL and testbench
====================================

Name: eic_irq_sequencer

Overview:
- Sits between the external interrupt controller (EIC) core and the MIPSfpga+ CPU EIC interface.
- Presents the highest pending interrupt to the CPU and tracks nested in-service levels on a stack.
- On CPU acknowledge, clears the taken flag through the EIC flag-clear registers.
- Arbitrates the EIC register write port between the AHB-Lite bus path and its own clear writes; clear writes win.

Parameters:
- NEST_DEPTH, 4, max nested in-service interrupts (stack entries, ≥1).
- IRQ_WIDTH, 6, width of interrupt number from the EIC priority encoder (64 channels).

Ports:
- CLK  in  1  clock.
- RESETn  in  1  synchronous active-low reset.
- irq_detected  in  1  EIC: at least one EIFR flag set.
- irq_number  in  IRQ_WIDTH  EIC: highest set flag index (higher index = higher priority).
- int_ack  in  1  CPU: one-cycle pulse, presented interrupt taken.
- eoi  in  1  CPU: one-cycle pulse, end of current handler.
- EIC_Interrupt  out  8  to CPU: presented number+1; 0 = none.
- EIC_Vector  out  6  EIC_Interrupt[5:0].
- bus_write_addr  in  4  bus-side EIC register address.
- bus_write_data  in  32  bus-side write data.
- bus_write_enable  in  1  bus-side write request; held until accepted.
- bus_write_ready  out  1  bus write accepted this cycle.
- write_addr  out  4  to EIC register file.
- write_data  out  32  to EIC register file.
- write_enable  out  1  to EIC register file.
- in_service_level  out  IRQ_WIDTH+1  top of stack as number+1; 0 = stack empty.
- eoi_error  out  1  one-cycle pulse, eoi received with empty stack.

Behaviour:
- One clock, CLK. Reset is synchronous and active-low on RESETn. Under reset:
  - state = IDLE, stack empty, EIC_Interrupt = 0, in_service_level = 0, eoi_error = 0.
  - No clear write is issued; bus_write_ready follows the IDLE rule.
- FSM states: IDLE, PRESENT, CLEAR, SETTLE.
- Eligible: irq_detected=1 AND irq_number+1 > in_service_level AND stack not full.
- IDLE:
  - If eligible at edge t, go to PRESENT.
  - EIC_Interrupt = irq_number+1 from t+1 (registered).
- PRESENT:
  - Re-evaluate every cycle. If eligible, update EIC_Interrupt to the current irq_number+1 (may rise).
  - If not eligible and no int_ack, go to IDLE; EIC_Interrupt = 0 next cycle.
  - On int_ack:
    - Latch n = presented number and push n onto the stack.
    - Go to CLEAR; EIC_Interrupt = 0 next cycle.
    - int_ack outside PRESENT is ignored.
- CLEAR (exactly 1 cycle):
  - write_enable=1, write_addr = EIFRC_0 (7) if n<32 else EIFRC_1 (8), write_data = 1<<(n mod 32).
  - bus_write_ready=0 (bus write stalls and must be held). Next state SETTLE.
- SETTLE (1 cycle): wait for the EIC priority encoder to reflect the cleared flag. bus path active. Next state IDLE.
- Bus path, all states except CLEAR:
  - write_addr/data = bus_write_addr/data; write_enable = bus_write_enable; bus_write_ready = 1.
  - These outputs are combinational.
- Stack, eoi handling:
  - eoi pops the stack; a new lower-priority level becomes eligible next cycle.
  - eoi on empty stack: no pop, eoi_error=1 for one cycle.
  - eoi and int_ack in the same cycle: pop first, then push; depth unchanged, top = n.
  - Stack full (depth = NEST_DEPTH): nothing eligible; EIC_Interrupt stays 0 until eoi.
- Latency:
  - irq_detected → EIC_Interrupt: 1 cycle.
  - int_ack → clear write: 1 cycle.
  - ack → next presentation possible: ≥3 cycles.
- Reset mid-CLEAR: write_enable drops immediately on the reset edge; EIFR flag stays set; stack empty.

Decomposition:
- Shared package eic_pkg: EIC register address constants (EIFRC_0=7, EIFRC_1=8, and the others), the FSM state encoding, and the EIC_Interrupt "none"=0 constant.
- One natural sub-module: eic_level_stack (push/pop/top/full/empty, parameter NEST_DEPTH, with a simultaneous pop+push rule).

Test Plan:
1. Reset, then irq_detected=1, irq_number=5 → EIC_Interrupt=6 one cycle later; bus_write_ready=1 throughout.
2. Presenting 5, int_ack → next cycle write_enable=1, write_addr=7, write_data=0x00000020, EIC_Interrupt=0; in_service_level=6. A bus write held during that cycle is accepted in SETTLE.
3. In service 40, irq_number=10 pending → EIC_Interrupt stays 0. Then eoi → EIC_Interrupt=11 within 2 cycles. Acking 40 earlier produced write_addr=8, write_data=0x00000100.
4. Nest ack 3, 9, 20, 33 (NEST_DEPTH=4), then irq_number=60 pending → EIC_Interrupt=0 until eoi; then presents 61.
5. eoi with empty stack → eoi_error pulses 1 cycle, no state change. Then eoi+int_ack same cycle at depth 1 → depth stays 1, top = new number.
6. Assert RESETn=0 during CLEAR → write_enable=0 that cycle, all outputs 0, stack empty, flag remains set and is re-presented after reset release.

Source files
------------

// File: rtl/eic_pkg.sv
// Shared definitions for the EIC interrupt sequencer: register map,
// sequencer state encoding and the "no interrupt" code.
package eic_pkg;

  // EIC register file addresses
  localparam logic [3:0] EICR    = 4'd0;
  localparam logic [3:0] EIMSK_0 = 4'd1;
  localparam logic [3:0] EIMSK_1 = 4'd2;
  localparam logic [3:0] EIFR_0  = 4'd3;
  localparam logic [3:0] EIFR_1  = 4'd4;
  localparam logic [3:0] EIFRS_0 = 4'd5;
  localparam logic [3:0] EIFRS_1 = 4'd6;
  localparam logic [3:0] EIFRC_0 = 4'd7;
  localparam logic [3:0] EIFRC_1 = 4'd8;

  // EIC_Interrupt value meaning "nothing presented"
  localparam logic [7:0] EIC_NONE = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_CLEAR   = 2'd2,
    ST_SETTLE  = 2'd3
  } eic_state_e;

endpackage

// File: rtl/eic_level_stack.sv
// Stack of in-service interrupt levels (number+1). A pop on an empty stack
// is ignored; a pop and push in the same cycle replace the top entry.
module eic_level_stack #(
  parameter int NEST_DEPTH = 4,
  parameter int LW         = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [LW-1:0] push_level,
  output logic [LW-1:0] top_level,
  output logic          full,
  output logic          empty
);

  localparam int CW = $clog2(NEST_DEPTH + 1);

  logic [LW-1:0] r_stack [NEST_DEPTH];
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;
  logic [CW-1:0] w_wr_idx;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(NEST_DEPTH));
  assign w_do_pop  = pop && !empty;
  // A push into a full stack is only possible when a pop frees the top slot
  assign w_do_push = push && (!full || w_do_pop);
  assign w_wr_idx  = w_do_pop ? (r_count - CW'(1)) : r_count;

  // Select the top entry; reads as 0 when the stack is empty
  always_comb begin
    top_level = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (r_count == CW'(i + 1)) top_level = r_stack[i];
    end
  end

  // Entry count: push and pop together leave the depth unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_do_push && !w_do_pop) begin
      r_count <= r_count + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Entry storage; contents beyond r_count are don't-care
  always_ff @(posedge clk) begin
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (w_do_push && (w_wr_idx == CW'(i))) r_stack[i] <= push_level;
    end
  end

endmodule

// File: rtl/eic_irq_sequencer.sv
// Presents the highest eligible EIC interrupt to the CPU, tracks nested
// in-service levels, and clears the taken EIFR flag after acknowledge.
module eic_irq_sequencer
  import eic_pkg::*;
#(
  parameter int NEST_DEPTH = 4,
  parameter int IRQ_WIDTH  = 6
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 irq_detected,
  input  logic [IRQ_WIDTH-1:0] irq_number,
  input  logic                 int_ack,
  input  logic                 eoi,
  output logic [7:0]           EIC_Interrupt,
  output logic [5:0]           EIC_Vector,
  input  logic [3:0]           bus_write_addr,
  input  logic [31:0]          bus_write_data,
  input  logic                 bus_write_enable,
  output logic                 bus_write_ready,
  output logic [3:0]           write_addr,
  output logic [31:0]          write_data,
  output logic                 write_enable,
  output logic [IRQ_WIDTH:0]   in_service_level,
  output logic                 eoi_error,
  output eic_state_e           dbg_state
);

  localparam int LW = IRQ_WIDTH + 1;

  eic_state_e           r_state;
  logic [7:0]           r_present;
  logic [IRQ_WIDTH-1:0] r_n;
  logic                 r_eoi_error;

  logic [LW-1:0] w_irq_level;
  logic          w_eligible;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic          w_clr_hi;

  assign w_irq_level = {1'b0, irq_number} + LW'(1);
  assign w_eligible  = irq_detected && (w_irq_level > in_service_level) && !w_full;
  assign w_push      = (r_state == ST_PRESENT) && int_ack;
  assign w_clr_hi    = (32'(r_n) >= 32'd32);

  eic_level_stack #(
    .NEST_DEPTH(NEST_DEPTH),
    .LW        (LW)
  ) u_stack (
    .clk       (CLK),
    .rst_n     (RESETn),
    .push      (w_push),
    .pop       (eoi),
    .push_level(r_present[LW-1:0]),
    .top_level (in_service_level),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Sequencer FSM with registered presentation, latched ack number and eoi error
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state     <= ST_IDLE;
      r_present   <= EIC_NONE;
      r_n         <= '0;
      r_eoi_error <= 1'b0;
    end else begin
      r_eoi_error <= eoi && w_empty;
      case (r_state)
        ST_IDLE: begin
          if (w_eligible) begin
            r_state   <= ST_PRESENT;
            r_present <= 8'(w_irq_level);
          end else begin
            r_present <= EIC_NONE;
          end
        end
        ST_PRESENT: begin
          if (int_ack) begin
            r_n       <= IRQ_WIDTH'(r_present - 8'd1);
            r_state   <= ST_CLEAR;
            r_present <= EIC_NONE;
          end else if (w_eligible) begin
            r_present <= 8'(w_irq_level);
          end else begin
            r_state   <= ST_IDLE;
            r_present <= EIC_NONE;
          end
        end
        ST_CLEAR: begin
          r_state   <= ST_SETTLE;
          r_present <= EIC_NONE;
        end
        default: begin
          // SETTLE: give the priority encoder a cycle to see the cleared flag
          r_state   <= ST_IDLE;
          r_present <= EIC_NONE;
        end
      endcase
    end
  end

  // Register write port. Bus handshake: a write transfers in any cycle where
  // bus_write_enable and bus_write_ready are both 1; the requester keeps
  // addr/data/enable stable until then. The clear write owns the port in CLEAR.
  always_comb begin
    write_addr      = bus_write_addr;
    write_data      = bus_write_data;
    write_enable    = bus_write_enable;
    bus_write_ready = 1'b1;
    if (r_state == ST_CLEAR) begin
      write_enable    = 1'b1;
      bus_write_ready = 1'b0;
      write_addr      = w_clr_hi ? EIFRC_1 : EIFRC_0;
      write_data      = 32'd1 << r_n[4:0];
    end
  end

  assign EIC_Interrupt = r_present;
  assign EIC_Vector    = r_present[5:0];
  assign eoi_error     = r_eoi_error;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_eic_irq_sequencer.sv
// Bench for eic_irq_sequencer: directed scenarios plus randomized acks, with
// queues of expected clear writes and bus writes checked by a write monitor.
module tb_eic_irq_sequencer;
  import eic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq_detected;
  logic [5:0]  irq_number;
  logic        int_ack;
  logic        eoi;
  logic [7:0]  eic_interrupt;
  logic [5:0]  eic_vector;
  logic [3:0]  bus_write_addr;
  logic [31:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_write_ready;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic [6:0]  in_service_level;
  logic        eoi_error;
  eic_state_e  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [35:0] clr_exp_q[$];
  logic [35:0] bus_exp_q[$];

  eic_irq_sequencer #(.NEST_DEPTH(4), .IRQ_WIDTH(6)) dut (
    .CLK             (clk),
    .RESETn          (rst_n),
    .irq_detected    (irq_detected),
    .irq_number      (irq_number),
    .int_ack         (int_ack),
    .eoi             (eoi),
    .EIC_Interrupt   (eic_interrupt),
    .EIC_Vector      (eic_vector),
    .bus_write_addr  (bus_write_addr),
    .bus_write_data  (bus_write_data),
    .bus_write_enable(bus_write_enable),
    .bus_write_ready (bus_write_ready),
    .write_addr      (write_addr),
    .write_data      (write_data),
    .write_enable    (write_enable),
    .in_service_level(in_service_level),
    .eoi_error       (eoi_error),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] clr_expect(input int n);
    logic [3:0]  a;
    logic [31:0] d;
    a = (n < 32) ? 4'd7 : 4'd8;
    d = 32'd1 << (n % 32);
    return {a, d};
  endfunction

  // Present irq k from IDLE, acknowledge it and return to IDLE with the flag cleared
  task automatic ack_irq(input int k);
    irq_number   = 6'(k);
    irq_detected = 1'b1;
    tick();
    chk("ack_present", 32'(eic_interrupt), 32'(k + 1));
    int_ack = 1'b1;
    clr_exp_q.push_back(clr_expect(k));
    tick();
    int_ack      = 1'b0;
    irq_detected = 1'b0;
    chk("ack_isl", 32'(in_service_level), 32'(k + 1));
    chk("ack_int0", 32'(eic_interrupt), 32'd0);
    tick();
    tick();
  endtask

  // scoreboard: write monitor on the falling edge
  always @(negedge clk) begin
    logic [35:0] e;
    if (write_enable && !bus_write_ready) begin
      if (clr_exp_q.size() == 0) begin
        chk("clr_unexpected", 32'd1, 32'd0);
      end else begin
        e = clr_exp_q.pop_front();
        chk("clr_addr", 32'(write_addr), 32'(e[35:32]));
        chk("clr_data", write_data, e[31:0]);
      end
    end else if (bus_write_enable && bus_write_ready) begin
      if (bus_exp_q.size() == 0) begin
        chk("bus_unexpected", 32'd1, 32'd0);
      end else begin
        e = bus_exp_q.pop_front();
        chk("bus_we", 32'(write_enable), 32'd1);
        chk("bus_addr", 32'(write_addr), 32'(e[35:32]));
        chk("bus_data", write_data, e[31:0]);
      end
    end
  end

  initial begin
    int n;
    rst_n            = 1'b0;
    irq_detected     = 1'b0;
    irq_number       = '0;
    int_ack          = 1'b0;
    eoi              = 1'b0;
    bus_write_addr   = '0;
    bus_write_data   = '0;
    bus_write_enable = 1'b0;

    // 1: reset state, first presentation
    repeat (3) tick();
    chk("rst_int", 32'(eic_interrupt), 32'd0);
    chk("rst_isl", 32'(in_service_level), 32'd0);
    chk("rst_eoierr", 32'(eoi_error), 32'd0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_ready", 32'(bus_write_ready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();
    irq_number   = 6'd5;
    irq_detected = 1'b1;
    tick();
    chk("t1_int", 32'(eic_interrupt), 32'd6);
    chk("t1_vec", 32'(eic_vector), 32'd6);
    chk("t1_ready", 32'(bus_write_ready), 32'd1);
    chk("t1_state", 32'(dbg_state), 32'(ST_PRESENT));

    // 2: ack 5, clear write, stalled bus write accepted in SETTLE
    int_ack = 1'b1;
    clr_exp_q.push_back(clr_expect(5));
    tick();
    int_ack          = 1'b0;
    irq_detected     = 1'b0;
    bus_write_addr   = 4'($urandom_range(0, 6));
    bus_write_data   = $urandom;
    bus_write_enable = 1'b1;
    bus_exp_q.push_back({bus_write_addr, bus_write_data});
    chk("t2_int0", 32'(eic_interrupt), 32'd0);
    chk("t2_isl", 32'(in_service_level), 32'd6);
    chk("t2_ready0", 32'(bus_write_ready), 32'd0);
    chk("t2_we", 32'(write_enable), 32'd1);
    chk("t2_addr", 32'(write_addr), 32'd7);
    chk("t2_data", write_data, 32'h0000_0020);
    tick();
    chk("t2_settle", 32'(dbg_state), 32'(ST_SETTLE));
    chk("t2_ready1", 32'(bus_write_ready), 32'd1);
    tick();
    bus_write_enable = 1'b0;
    chk("t2_idle", 32'(dbg_state), 32'(ST_IDLE));
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("t2_pop", 32'(in_service_level), 32'd0);

    // 3: 40 in service blocks 10 until eoi
    ack_irq(40);
    irq_number   = 6'd10;
    irq_detected = 1'b1;
    tick();
    chk("t3_block_a", 32'(eic_interrupt), 32'd0);
    tick();
    chk("t3_block_b", 32'(eic_interrupt), 32'd0);
    chk("t3_isl", 32'(in_service_level), 32'd41);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("t3_isl0", 32'(in_service_level), 32'd0);
    tick();
    chk("t3_present", 32'(eic_interrupt), 32'd11);
    irq_detected = 1'b0;
    tick();
    chk("t3_drop", 32'(eic_interrupt), 32'd0);
    tick();

    // 4: nest to full depth, then 60 waits for an eoi
    ack_irq(3);
    ack_irq(9);
    ack_irq(20);
    ack_irq(33);
    irq_number   = 6'd60;
    irq_detected = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_full_block", 32'(eic_interrupt), 32'd0);
    end
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("t4_isl21", 32'(in_service_level), 32'd21);
    tick();
    chk("t4_present61", 32'(eic_interrupt), 32'd61);
    irq_detected = 1'b0;
    tick();
    eoi = 1'b1;
    tick();
    chk("t4_isl10", 32'(in_service_level), 32'd10);
    tick();
    chk("t4_isl4", 32'(in_service_level), 32'd4);
    tick();
    eoi = 1'b0;
    chk("t4_isl0", 32'(in_service_level), 32'd0);
    tick();

    // 5: eoi on empty stack, then eoi+ack together at depth 1
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("t5_err", 32'(eoi_error), 32'd1);
    chk("t5_err_isl", 32'(in_service_level), 32'd0);
    chk("t5_err_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    chk("t5_err_pulse", 32'(eoi_error), 32'd0);
    ack_irq(12);
    irq_number   = 6'd50;
    irq_detected = 1'b1;
    tick();
    chk("t5_present51", 32'(eic_interrupt), 32'd51);
    int_ack = 1'b1;
    eoi     = 1'b1;
    clr_exp_q.push_back(clr_expect(50));
    tick();
    int_ack      = 1'b0;
    eoi          = 1'b0;
    irq_detected = 1'b0;
    chk("t5_swap_top", 32'(in_service_level), 32'd51);
    chk("t5_swap_noerr", 32'(eoi_error), 32'd0);
    tick();
    tick();
    eoi = 1'b1;
    tick();
    chk("t5_depth1_pop", 32'(in_service_level), 32'd0);
    chk("t5_depth1_noerr", 32'(eoi_error), 32'd0);
    tick();
    eoi = 1'b0;
    chk("t5_depth1_err", 32'(eoi_error), 32'd1);
    tick();

    // randomized single acks
    for (int i = 0; i < 4; i++) begin
      n = int'($urandom_range(0, 63));
      ack_irq(n);
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      chk("rnd_pop", 32'(in_service_level), 32'd0);
    end

    // 6: reset during CLEAR
    irq_number   = 6'd7;
    irq_detected = 1'b1;
    tick();
    chk("t6_present", 32'(eic_interrupt), 32'd8);
    int_ack = 1'b1;
    clr_exp_q.push_back(clr_expect(7));
    tick();
    int_ack = 1'b0;
    rst_n   = 1'b0;
    chk("t6_in_clear", 32'(dbg_state), 32'(ST_CLEAR));
    tick();
    chk("t6_we", 32'(write_enable), 32'd0);
    chk("t6_int", 32'(eic_interrupt), 32'd0);
    chk("t6_isl", 32'(in_service_level), 32'd0);
    chk("t6_eoierr", 32'(eoi_error), 32'd0);
    chk("t6_ready", 32'(bus_write_ready), 32'd1);
    chk("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();
    chk("t6_represent", 32'(eic_interrupt), 32'd8);
    irq_detected = 1'b0;
    tick();
    tick();

    chk("clr_q_empty", 32'(clr_exp_q.size()), 32'd0);
    chk("bus_q_empty", 32'(bus_exp_q.size()), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
